// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM states and flag indices
// for the ALU command sequencer.
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MULT = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_LDI  = 3'd6;
  localparam logic [2:0] OP_RD   = 3'd7;

  localparam int FLG_Z = 3;
  localparam int FLG_N = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

endpackage

// File: rtl/alu_regfile.sv
// NREG x 8 register file: two async reads, one sync
// write that can also place a high byte at addr+1.
module alu_regfile #(
  parameter int NREG = 8,
  localparam int RW = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [RW-1:0] ra_addr,
  output logic [7:0]    ra_data,
  input  logic [RW-1:0] rb_addr,
  output logic [7:0]    rb_data,
  input  logic          we,
  input  logic          wide,
  input  logic [RW-1:0] waddr,
  input  logic [15:0]   wdata
);

  logic [7:0]    mem [NREG];
  logic [RW-1:0] hi_addr;

  // Wraps naturally at NREG since RW bits cover it exactly
  assign hi_addr = waddr + RW'(1);

  assign ra_data = mem[ra_addr];
  assign rb_data = mem[rb_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata[7:0];
      if (wide)
        mem[hi_addr] <= wdata[15:8];
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Command-driven initiator for the external 8-bit ALU:
// fetch operands, run one op, write back, respond.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NREG = 8,
  localparam int RW = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [RW-1:0] cmd_ra,
  input  logic [RW-1:0] cmd_rb,
  input  logic [RW-1:0] cmd_rd,
  input  logic [7:0]    cmd_imm,
  output logic [7:0]    alu_A,
  output logic [7:0]    alu_B,
  output logic [2:0]    alu_S,
  input  logic [15:0]   alu_o,
  input  logic          alu_zero,
  input  logic          alu_negative,
  input  logic          alu_carry,
  input  logic          alu_overflow,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [15:0]   rsp_data,
  output logic [3:0]    rsp_flags
);

  state_t        state_q, state_d;
  logic [RW-1:0] rd_q;
  logic [7:0]    imm_q;
  logic [7:0]    ra_data, rb_data;
  logic          accept;
  logic          in_exec;
  logic          wb_en;
  logic          wb_wide;
  logic [15:0]   wb_data;
  logic [15:0]   res_data;
  logic [3:0]    res_flags;

  assign accept  = (state_q == IDLE) && cmd_valid;
  assign in_exec = (state_q == EXEC);

  assign wb_en   = in_exec && (alu_S != OP_RD);
  assign wb_wide = (alu_S == OP_MULT);
  assign wb_data = (alu_S == OP_LDI) ? {8'h00, imm_q} : alu_o;

  alu_regfile #(.NREG(NREG)) u_rf (
    .clk     (clk),
    .rst     (rst),
    .ra_addr (cmd_ra),
    .ra_data (ra_data),
    .rb_addr (cmd_rb),
    .rb_data (rb_data),
    .we      (wb_en),
    .wide    (wb_wide),
    .waddr   (rd_q),
    .wdata   (wb_data)
  );

  // alu_A already holds reg[ra] captured at acceptance, so RD reuses it
  always_comb begin
    res_data  = alu_o;
    res_flags = '0;
    unique case (1'b1)
      alu_S == OP_LDI: begin
        res_data         = {8'h00, imm_q};
        res_flags[FLG_Z] = (imm_q == 8'h00);
      end
      alu_S == OP_RD: begin
        res_data         = {8'h00, alu_A};
        res_flags[FLG_Z] = (alu_A == 8'h00);
      end
      default: begin
        res_data         = alu_o;
        res_flags[FLG_Z] = alu_zero;
        res_flags[FLG_N] = alu_negative;
        res_flags[FLG_C] = alu_carry;
        res_flags[FLG_V] = alu_overflow;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid)
          state_d = EXEC;
      end
      EXEC: state_d = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rd_q      <= '0;
      imm_q     <= '0;
      alu_A     <= '0;
      alu_B     <= '0;
      alu_S     <= '0;
      rsp_data  <= '0;
      rsp_flags <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rd_q  <= cmd_rd;
        imm_q <= cmd_imm;
        alu_A <= ra_data;
        alu_B <= rb_data;
        alu_S <= cmd_op;
      end
      if (in_exec) begin
        rsp_data  <= res_data;
        rsp_flags <= res_flags;
      end
    end
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Command-driven controller that sits in front of the combinational 8-bit ALU and acts as its initiator. It accepts operation commands over a valid/ready interface and reads operands from a small internal register file. It drives the ALU's A/B/S inputs, captures the 16-bit result and the four flags, writes the result back, and returns it over a valid/ready response interface.

## Interface
- NREG, 8, number of 8-bit registers; power of two, index width RW = log2(NREG)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  3  opcode
- cmd_ra  in  RW  operand-A register index
- cmd_rb  in  RW  operand-B register index
- cmd_rd  in  RW  destination register index
- cmd_imm  in  8  immediate for LDI
- alu_A  out  8  ALU operand A (registered)
- alu_B  out  8  ALU operand B (registered)
- alu_S  out  3  ALU select (registered)
- alu_o  in  16  ALU result
- alu_zero, alu_negative, alu_carry, alu_overflow  in  1 each  ALU flags
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  16  result
- rsp_flags  out  4  {zero, negative, carry, overflow}

## Operation
- Opcodes:
  - 000 ADD, 001 SUB, 010 MULT, 011 AND, 100 OR, 101 XOR: ALU ops.
  - 110 LDI: load immediate; the ALU is not used.
  - 111 RD: read register; the ALU is not used.
- The FSM has three states: IDLE, EXEC, RESP.
  - IDLE: cmd_ready=1. On cmd_valid, latch op/rd/imm and set alu_A=reg[ra], alu_B=reg[rb], alu_S=op, then go to EXEC.
  - EXEC: one cycle for the ALU to settle. At the end of EXEC, capture the response and perform writeback, then go to RESP.
  - RESP: rsp_valid=1. On rsp_ready, go to IDLE.
- Response capture per opcode:
  - ALU ops: rsp_data=alu_o; rsp_flags=ALU flags, copied verbatim regardless of opcode.
  - LDI: rsp_data={8'h00,imm}; zero=(imm==0); other flags 0.
  - RD: rsp_data={8'h00,reg[ra]}; flags as for LDI, computed on reg[ra].
- Writeback:
  - ALU ops: reg[rd] = alu_o[7:0].
  - MULT additionally writes reg[(rd+1) mod NREG] = alu_o[15:8]. With rd=NREG-1 this wraps to r0.
  - LDI: reg[rd] = imm.
  - RD: no write.
- All registers are general purpose; r0 is writable.
- Operands are read at acceptance. Commands are strictly serialized, so the previous writeback is always visible to the next command.
- cmd_ready is 0 in EXEC and RESP; cmd_valid is ignored there.
- Reset (any state, including mid-command): state=IDLE, every register file entry=0, alu_A/alu_B/alu_S=0, rsp_valid=0, rsp_data=0, rsp_flags=0. Any pending command or response is discarded with no writeback.

## Timing
- Cycle-accurate sequence:
  - Command accepted on edge k.
  - ALU inputs are stable during cycle k+1 (EXEC).
  - Response and writeback are registered on edge k+1.
  - rsp_valid is high from cycle k+2.
- Latency from accept to rsp_valid is 2 cycles. Minimum period is 3 cycles per command: cmd_ready returns in the cycle after the rsp handshake edge.
- rsp_data and rsp_flags stay stable while rsp_valid=1 and rsp_ready=0.
- rsp_ready held high in advance completes the handshake in the first RESP cycle.
- alu_A, alu_B and alu_S hold their last values outside EXEC; they change only on command acceptance or reset.

## Structure
- Package alu_seq_pkg holds:
  - opcode constants OP_ADD..OP_XOR, OP_LDI, OP_RD;
  - the state enum {IDLE, EXEC, RESP};
  - flag bit indices FLG_Z=3, FLG_N=2, FLG_C=1, FLG_V=0.
- Sub-module alu_regfile (NREG x 8):
  - two asynchronous read ports;
  - one synchronous write port with a wide-write enable that writes the low byte to addr and the high byte to (addr+1) mod NREG;
  - synchronous clear on rst.
- The ALU itself is instantiated by the parent, not inside this block.

## Test plan
- LDI r1=0x0F, LDI r2=0xF1, ADD r3=r1,r2 -> rsp_data=0x0100, flags carry=1, zero=0; then RD r3 -> rsp_data=0x0000, zero=1.
- MULT r4=r1,r2 (0x0F*0xF1) -> rsp_data=0x0E1F; RD r4 -> 0x001F; RD r5 -> 0x000E.
- LDI r6=0x05, LDI r7=0x07, SUB rd=7 with ra=6, rb=7 -> rsp_data=0x01FE, r7=0xFE. Then MULT rd=7 with ra=7, rb=7 (0xFE*0xFE=0xFC04) -> r7=0x04, r0=0xFC; RD r0 -> 0x00FC.
- Hold rsp_ready=0 for 5 cycles while driving cmd_valid=1 -> rsp_data/rsp_flags unchanged, cmd_ready=0, no second command accepted. After the handshake, cmd_ready=1 in the next cycle.
- Assert rst during EXEC of ADD -> rsp_valid never rises, destination register remains 0, all outputs 0. The next LDI r1=0xAA followed by RD r1 returns 0x00AA.
- Back-to-back commands with rsp_ready tied high -> exactly one accept per 3 cycles; rsp_valid 2 cycles after each accept.
